regfile_32x32: RTL and testbench
================================

# regfile_32x32

Architectural register file for the processor datapath. It sits directly downstream of the 5-to-32 write-address decode, whose 32 one-hot enables gate the clocked write into one of 32 registers. It provides two combinational read ports to the operand-fetch stage and one synchronous write port from writeback. Register 0 is hardwired to zero.

## Interface
Parameters:
- WIDTH, 32, data width of each register and of every data port
- BYPASS, 0, 1 = a read of the register being written this cycle returns data_writeReg (write-through); 0 = it returns the stored (old) value

Ports:
- clock  in  1  system clock, rising-edge active
- ctrl_reset_n  in  1  reset, asynchronous, active-low; clears all registers
- ctrl_writeEnable  in  1  write strobe, sampled on rising clock edge
- ctrl_writeReg  in  5  write address
- data_writeReg  in  WIDTH  write data
- ctrl_readRegA  in  5  read address, port A
- ctrl_readRegB  in  5  read address, port B
- data_readRegA  out  WIDTH  read data, port A
- data_readRegB  out  WIDTH  read data, port B

Clocking and reset, fixed: one clock, `clock`; reset is asynchronous and active-low, `ctrl_reset_n`.

## Operation
- Storage: 32 registers, r0..r31, each WIDTH bits. r0 has no storage element and always reads 0.
- Write decode: ctrl_writeReg is one-hot decoded to 32 enables. Each enable is ANDed with ctrl_writeEnable. Enable 0 is discarded.
- Write: on a rising clock edge with ctrl_reset_n=1, ctrl_writeEnable=1 and ctrl_writeReg=k (k≠0), r[k] ← data_writeReg. All other registers hold.
- Write to r0: ignored. No state changes and no error is flagged.
- Reads: fully combinational. data_readRegA = r[ctrl_readRegA]; data_readRegB = r[ctrl_readRegB]. Implemented as a 32:1 mux per port.
- Both ports may address the same register, including r0 and including the register being written. Both return identical data.
- BYPASS=1: if ctrl_writeEnable=1, ctrl_writeReg=k≠0 and a read address equals k, that port outputs data_writeReg combinationally. Otherwise it outputs the stored value. A read of r0 never bypasses.
- BYPASS=0: a port reading the register being written shows the old value until the edge and the new value after it.
- Reset: while ctrl_reset_n=0, all registers are held at 0 and both read ports output 0 (BYPASS ignored). Writes are blocked.

## Timing
- Reset values: every register is 0, so data_readRegA = data_readRegB = 0 for any address.
- Reset assertion takes effect immediately, without waiting for a clock edge, including mid-write. A write whose edge coincides with assertion is lost.
- Reset release: the first rising edge with ctrl_reset_n=1 may perform a write.
- Write latency: 1 edge. With BYPASS=0, data is readable in the cycle after the write edge. With BYPASS=1, data is readable in the same cycle, before the edge.
- Read latency: 0 cycles, combinational from address and stored state. Back-to-back writes to the same register: the last one wins at each edge.
- Address, data and enable are sampled only at the rising edge. Glitches between edges have no effect on state.

## Test plan
- Reset: drive ctrl_reset_n=0 asynchronously mid-cycle after loading r5=0xDEADBEEF -> both ports read 0 for r5 immediately, with no clock edge needed. After release, r5 still reads 0.
- Write/readback: write r1=0x00000001, r17=0xA5A5A5A5, r31=0xFFFFFFFF on consecutive edges -> after the edges, A=r17 reads 0xA5A5A5A5 and B=r31 reads 0xFFFFFFFF; all other registers read 0.
- r0 immutability: write r0=0x12345678 with enable=1 -> both ports addressing r0 read 0x00000000, both before and after the edge.
- Enable gating: ctrl_writeEnable=0, ctrl_writeReg=9, data=0xCAFEF00D -> after the edge, r9 keeps its previous value.
- Read-during-write: r3=0x11 stored; write r3=0x22 with A=B=3. With BYPASS=0, both ports read 0x11 before the edge and 0x22 after it. With BYPASS=1, both ports read 0x22 before the edge.
- Full sweep: write r[i]=i·0x01010101 for i=0..31, then read every address on both ports -> r0 reads 0 and r[i] reads i·0x01010101 for i≥1, with no aliasing between registers.

Source files
------------

// File: rtl/regfile_32x32.sv
// 32 x WIDTH architectural register file, r0 hardwired to zero.
// Two combinational read ports, one clocked write port, optional write-through.
module regfile_32x32 #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             ctrl_writeEnable,
  input  logic [4:0]       ctrl_writeReg,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic [4:0]       ctrl_readRegA,
  input  logic [4:0]       ctrl_readRegB,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB
);

  logic [WIDTH-1:0] regs [1:31];
  logic [31:1]      wen;

  always_comb begin
    wen = '0;
    for (int i = 1; i < 32; i++) begin
      wen[i] = ctrl_writeEnable &&
               (ctrl_writeReg == 5'(i));
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wen[i]) begin
          regs[i] <= data_writeReg;
        end
      end
    end
  end

  logic byp_a;
  logic byp_b;

  // r0 never bypasses; reset forces both ports to zero
  always_comb begin
    byp_a = BYPASS && ctrl_writeEnable &&
            (ctrl_writeReg != 5'd0) &&
            (ctrl_writeReg == ctrl_readRegA);
    byp_b = BYPASS && ctrl_writeEnable &&
            (ctrl_writeReg != 5'd0) &&
            (ctrl_writeReg == ctrl_readRegB);
  end

  always_comb begin
    data_readRegA = '0;
    for (int i = 1; i < 32; i++) begin
      if (ctrl_readRegA == 5'(i)) begin
        data_readRegA = regs[i];
      end
    end
    if (byp_a) begin
      data_readRegA = data_writeReg;
    end
    if (!ctrl_reset_n) begin
      data_readRegA = '0;
    end
  end

  always_comb begin
    data_readRegB = '0;
    for (int i = 1; i < 32; i++) begin
      if (ctrl_readRegB == 5'(i)) begin
        data_readRegB = regs[i];
      end
    end
    if (byp_b) begin
      data_readRegB = data_writeReg;
    end
    if (!ctrl_reset_n) begin
      data_readRegB = '0;
    end
  end

endmodule

// File: tb/tb_regfile_32x32.sv
// Directed bench for regfile_32x32.
// Runs a BYPASS=0 and a BYPASS=1 instance side by side on shared inputs.
module tb_regfile_32x32;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [31:0] a0, b0, a1, b1;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  regfile_32x32 #(.WIDTH(32), .BYPASS(1'b0)) dut0 (
    .clock(clock), .ctrl_reset_n(rst_n),
    .ctrl_writeEnable(we), .ctrl_writeReg(wa),
    .data_writeReg(wd),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(a0), .data_readRegB(b0)
  );

  regfile_32x32 #(.WIDTH(32), .BYPASS(1'b1)) dut1 (
    .clock(clock), .ctrl_reset_n(rst_n),
    .ctrl_writeEnable(we), .ctrl_writeReg(wa),
    .data_writeReg(wd),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(a1), .data_readRegB(b1)
  );

  task automatic wr(input logic [4:0] k, input logic [31:0] d);
    @(negedge clock);
    we = 1'b1; wa = k; wd = d;
    @(posedge clock);
    #1;
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    we = 1'b1; wa = 5'd5; wd = 32'h5555_5555;
    ra = 5'd5; rb = 5'd31;
    #1;
    tests++;
    if (a0 !== 32'h0) begin fails++;
      $display("FAIL reset_a0 got %h exp %h", a0, 32'h0); end
    tests++;
    if (b0 !== 32'h0) begin fails++;
      $display("FAIL reset_b0 got %h exp %h", b0, 32'h0); end
    tests++;
    if (a1 !== 32'h0) begin fails++;
      $display("FAIL reset_byp_a1 got %h exp %h", a1, 32'h0); end
    @(posedge clock); #1;
    tests++;
    if (a0 !== 32'h0) begin fails++;
      $display("FAIL reset_blockwr got %h exp %h", a0, 32'h0); end
    we = 1'b0;
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock); #1;
    tests++;
    if (a0 !== 32'h0) begin fails++;
      $display("FAIL reset_after got %h exp %h", a0, 32'h0); end
  endtask

  task automatic test_write_readback();
    logic [31:0] exp;
    wr(5'd1, 32'h0000_0001);
    wr(5'd17, 32'hA5A5_A5A5);
    wr(5'd31, 32'hFFFF_FFFF);
    ra = 5'd17; rb = 5'd31; #1;
    tests++;
    if (a0 !== 32'hA5A5_A5A5) begin fails++;
      $display("FAIL wr_r17 got %h exp %h", a0, 32'hA5A5_A5A5); end
    tests++;
    if (b0 !== 32'hFFFF_FFFF) begin fails++;
      $display("FAIL wr_r31 got %h exp %h", b0, 32'hFFFF_FFFF); end
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(i); #1;
      exp = (i == 1)  ? 32'h0000_0001 :
            (i == 17) ? 32'hA5A5_A5A5 :
            (i == 31) ? 32'hFFFF_FFFF : 32'h0;
      tests++;
      if (a0 !== exp || b0 !== exp) begin fails++;
        $display("FAIL wr_scan r%0d got %h/%h exp %h", i, a0, b0, exp); end
    end
  endtask

  task automatic test_r0();
    @(negedge clock);
    we = 1'b1; wa = 5'd0; wd = 32'h1234_5678;
    ra = 5'd0; rb = 5'd0; #1;
    tests++;
    if (a0 !== 32'h0 || b0 !== 32'h0) begin fails++;
      $display("FAIL r0_pre got %h/%h exp 0", a0, b0); end
    tests++;
    if (a1 !== 32'h0 || b1 !== 32'h0) begin fails++;
      $display("FAIL r0_pre_byp got %h/%h exp 0", a1, b1); end
    @(posedge clock); #1;
    we = 1'b0; #1;
    tests++;
    if (a0 !== 32'h0 || b0 !== 32'h0) begin fails++;
      $display("FAIL r0_post got %h/%h exp 0", a0, b0); end
    tests++;
    if (a1 !== 32'h0 || b1 !== 32'h0) begin fails++;
      $display("FAIL r0_post_byp got %h/%h exp 0", a1, b1); end
  endtask

  task automatic test_enable();
    wr(5'd9, 32'h0000_0099);
    @(negedge clock);
    we = 1'b0; wa = 5'd9; wd = 32'hCAFE_F00D;
    ra = 5'd9; rb = 5'd9;
    @(posedge clock); #1;
    tests++;
    if (a0 !== 32'h0000_0099) begin fails++;
      $display("FAIL enable_gate got %h exp %h", a0, 32'h99); end
    tests++;
    if (b1 !== 32'h0000_0099) begin fails++;
      $display("FAIL enable_gate_byp got %h exp %h", b1, 32'h99); end
  endtask

  task automatic test_rdw();
    wr(5'd3, 32'h0000_0011);
    @(negedge clock);
    we = 1'b1; wa = 5'd3; wd = 32'h0000_0022;
    ra = 5'd3; rb = 5'd3; #1;
    tests++;
    if (a0 !== 32'h11 || b0 !== 32'h11) begin fails++;
      $display("FAIL rdw_pre got %h/%h exp %h", a0, b0, 32'h11); end
    tests++;
    if (a1 !== 32'h22 || b1 !== 32'h22) begin fails++;
      $display("FAIL rdw_byp_pre got %h/%h exp %h", a1, b1, 32'h22); end
    @(posedge clock); #1;
    we = 1'b0; #1;
    tests++;
    if (a0 !== 32'h22 || b0 !== 32'h22) begin fails++;
      $display("FAIL rdw_post got %h/%h exp %h", a0, b0, 32'h22); end
    tests++;
    if (a1 !== 32'h22 || b1 !== 32'h22) begin fails++;
      $display("FAIL rdw_byp_post got %h/%h exp %h", a1, b1, 32'h22); end
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    we = 1'b1; wa = 5'd4; wd = 32'h0000_0001;
    @(negedge clock);
    wd = 32'h0000_0002;
    @(posedge clock); #1;
    we = 1'b0;
    ra = 5'd4; rb = 5'd3; #1;
    tests++;
    if (a0 !== 32'h2) begin fails++;
      $display("FAIL b2b_last got %h exp %h", a0, 32'h2); end
    tests++;
    if (b0 !== 32'h22) begin fails++;
      $display("FAIL b2b_neighbor got %h exp %h", b0, 32'h22); end
  endtask

  task automatic test_sweep();
    logic [31:0] ea, eb;
    for (int i = 0; i < 32; i++) begin
      wr(5'(i), 32'(i) * 32'h0101_0101);
    end
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i); #1;
      ea = 32'(i) * 32'h0101_0101;
      eb = 32'(31 - i) * 32'h0101_0101;
      tests++;
      if (a0 !== ea || b0 !== eb) begin fails++;
        $display("FAIL sweep i=%0d got %h/%h exp %h/%h", i, a0, b0, ea, eb); end
      tests++;
      if (a1 !== ea || b1 !== eb) begin fails++;
        $display("FAIL sweep_byp i=%0d got %h/%h exp %h/%h", i, a1, b1, ea, eb); end
    end
  endtask

  task automatic test_async_reset();
    wr(5'd5, 32'hDEAD_BEEF);
    ra = 5'd5; rb = 5'd5; #1;
    tests++;
    if (a0 !== 32'hDEAD_BEEF) begin fails++;
      $display("FAIL arst_load got %h exp %h", a0, 32'hDEADBEEF); end
    @(negedge clock);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (a0 !== 32'h0 || b0 !== 32'h0) begin fails++;
      $display("FAIL arst_immediate got %h/%h exp 0", a0, b0); end
    tests++;
    if (a1 !== 32'h0 || b1 !== 32'h0) begin fails++;
      $display("FAIL arst_immediate_byp got %h/%h exp 0", a1, b1); end
    @(negedge clock);
    we = 1'b1; wa = 5'd7; wd = 32'h0000_0077;
    rst_n = 1'b1;
    @(posedge clock); #1;
    we = 1'b0;
    rb = 5'd7; #1;
    tests++;
    if (a0 !== 32'h0) begin fails++;
      $display("FAIL arst_r5_after got %h exp 0", a0); end
    tests++;
    if (b0 !== 32'h77) begin fails++;
      $display("FAIL arst_first_edge_wr got %h exp %h", b0, 32'h77); end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_r0();
    test_enable();
    test_rdw();
    test_back_to_back();
    test_sweep();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
